// File: rtl/uart_cmd_parser_pkg.sv
// Shared definitions for the UART command parser: ASCII terminators, FSM state
// encoding and the hex-character decoder.
package uart_cmd_parser_pkg;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DIGIT = 2'd1,
    ST_ERR   = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  typedef struct packed {
    logic       vld;
    logic [3:0] nib;
  } hex_t;

  // Letters map via their low nibble: 'A'/'a' end in 1, so adding 9 gives 10.
  function automatic hex_t hex_decode(input logic [7:0] c);
    hex_t r;
    r.vld = 1'b0;
    r.nib = 4'h0;
    if (c >= 8'h30 && c <= 8'h39) begin
      r.vld = 1'b1;
      r.nib = c[3:0];
    end else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66)) begin
      r.vld = 1'b1;
      r.nib = c[3:0] + 4'd9;
    end
    return r;
  endfunction

  function automatic logic is_term(input logic [7:0] c);
    return (c == ASCII_CR) || (c == ASCII_LF);
  endfunction

endpackage

// File: rtl/uart_cmd_parser.sv
// Assembles fixed-length hex command lines from a UART byte stream into an
// instruction word with valid/ready handoff. Define UART_CMD_ECHO_EN to echo bytes.
module uart_cmd_parser
  import uart_cmd_parser_pkg::*;
#(
  parameter int INST_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            i_rx_data,
  input  logic                  i_rx_valid,
  output logic [INST_WIDTH-1:0] o_inst,
  output logic                  o_inst_valid,
  input  logic                  i_inst_ready,
  output logic                  o_cmd_err,
  output logic                  o_overrun,
  output logic [7:0]            o_echo_data,
  output logic                  o_echo_stb
);

  localparam int N_DIG = INST_WIDTH / 4;
  localparam int CNT_W = $clog2(N_DIG + 1);
  localparam logic [CNT_W-1:0] N_CNT = CNT_W'(N_DIG);

  state_t                  state_q;
  logic [CNT_W-1:0]        count_q;
  logic [INST_WIDTH-1:0]   inst_q;
  logic                    inst_valid_q;
  logic                    cmd_err_q;
  logic                    overrun_q;
  state_t                  cur_st;
  hex_t                    hex;
  logic                    term;

  // A released HOLD behaves exactly like IDLE for the byte arriving alongside ready.
  assign cur_st = (state_q == ST_HOLD) ? ST_IDLE : state_q;
  assign hex    = hex_decode(i_rx_data);
  assign term   = is_term(i_rx_data);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      count_q      <= '0;
      inst_q       <= '0;
      inst_valid_q <= 1'b0;
      cmd_err_q    <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      cmd_err_q <= 1'b0;
      overrun_q <= 1'b0;
      if (state_q == ST_HOLD && !i_inst_ready) begin
        if (i_rx_valid) overrun_q <= 1'b1;
      end else if (!i_rx_valid) begin
        if (state_q == ST_HOLD) begin
          state_q      <= ST_IDLE;
          count_q      <= '0;
          inst_valid_q <= 1'b0;
        end
      end else begin
        inst_valid_q <= 1'b0;
        case (cur_st)
          ST_IDLE: begin
            if (term) begin
              state_q <= ST_IDLE;
              count_q <= '0;
            end else if (hex.vld) begin
              inst_q  <= {inst_q[INST_WIDTH-5:0], hex.nib};
              count_q <= CNT_W'(1);
              state_q <= ST_DIGIT;
            end else begin
              state_q <= ST_ERR;
            end
          end
          ST_DIGIT: begin
            if (hex.vld) begin
              if (count_q < N_CNT) begin
                inst_q  <= {inst_q[INST_WIDTH-5:0], hex.nib};
                count_q <= count_q + CNT_W'(1);
              end else begin
                state_q <= ST_ERR;
              end
            end else if (term) begin
              count_q <= '0;
              if (count_q == N_CNT) begin
                state_q      <= ST_HOLD;
                inst_valid_q <= 1'b1;
              end else begin
                state_q   <= ST_IDLE;
                cmd_err_q <= 1'b1;
              end
            end else begin
              state_q <= ST_ERR;
            end
          end
          ST_ERR: begin
            if (term) begin
              state_q   <= ST_IDLE;
              count_q   <= '0;
              cmd_err_q <= 1'b1;
            end
          end
          default: begin
            state_q <= ST_IDLE;
            count_q <= '0;
          end
        endcase
      end
    end
  end

  assign o_inst       = inst_q;
  assign o_inst_valid = inst_valid_q;
  assign o_cmd_err    = cmd_err_q;
  assign o_overrun    = overrun_q;

`ifdef UART_CMD_ECHO_EN
  logic [7:0] echo_data_q;
  logic       echo_stb_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      echo_data_q <= 8'h00;
      echo_stb_q  <= 1'b0;
    end else begin
      echo_stb_q <= i_rx_valid;
      if (i_rx_valid) echo_data_q <= i_rx_data;
    end
  end

  assign o_echo_data = echo_data_q;
  assign o_echo_stb  = echo_stb_q;
`else
  assign o_echo_data = 8'h00;
  assign o_echo_stb  = 1'b0;
`endif

endmodule
